// File: rtl/phase_meter.sv
// Phase/high-time/period meter for a square wave on sig_in, timed against a free-running
// reference that matches the channel clock divider so the phase can be written straight back.
module phase_meter #(
  parameter int OFFSET_WIDTH   = 11,
  parameter int CNT_WIDTH      = 12,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OFFSET_WIDTH-2:0] divide,
  input  logic                    sig_in,
  input  logic                    start,
  input  logic                    ack,
  output logic                    busy,
  output logic                    valid,
  output logic                    timeout,
  output logic [OFFSET_WIDTH-1:0] offset,
  output logic [CNT_WIDTH-1:0]    high_time,
  output logic [CNT_WIDTH-1:0]    period
);

  localparam int CW = OFFSET_WIDTH - 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEEK_LOW,
    WAIT_RISE,
    WAIT_FALL,
    WAIT_RISE2,
    DONE
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]           ref_cnt;
  logic                    ref_half;
  logic                    s1, s2, s3;
  logic                    rise, fall;
  logic [OFFSET_WIDTH-1:0] phase_adj;
  logic [CNT_WIDTH-1:0]    meas_cnt, meas_inc;
  logic [WW-1:0]           wait_cnt;
  logic                    waiting, wait_expired, to_timeout;

  // Reference runs regardless of state; >= lets a reduced divide wrap immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt  <= '0;
      ref_half <= 1'b0;
    end else if (ref_cnt >= divide) begin
      ref_cnt  <= '0;
      ref_half <= ~ref_half;
    end else begin
      ref_cnt <= ref_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Back the reference off by the two synchroniser cycles, wrapping across the half boundary.
  always_comb begin
    if (ref_cnt >= CW'(2))
      phase_adj = {ref_half, ref_cnt - CW'(2)};
    else
      phase_adj = {~ref_half, ref_cnt + divide - CW'(1)};
  end

  assign meas_inc     = (meas_cnt == '1) ? meas_cnt : meas_cnt + CNT_WIDTH'(1);
  assign waiting      = (state == SEEK_LOW) || (state == WAIT_RISE) ||
                        (state == WAIT_FALL) || (state == WAIT_RISE2);
  assign wait_expired = waiting && (wait_cnt >= WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    to_timeout = 1'b0;
    unique case (state)
      IDLE:       if (start) state_next = SEEK_LOW;
      SEEK_LOW:   if (!s2) state_next = WAIT_RISE;
                  else if (wait_expired) begin state_next = DONE; to_timeout = 1'b1; end
      WAIT_RISE:  if (rise) state_next = WAIT_FALL;
                  else if (wait_expired) begin state_next = DONE; to_timeout = 1'b1; end
      WAIT_FALL:  if (fall) state_next = WAIT_RISE2;
                  else if (wait_expired) begin state_next = DONE; to_timeout = 1'b1; end
      WAIT_RISE2: if (rise) state_next = DONE;
                  else if (wait_expired) begin state_next = DONE; to_timeout = 1'b1; end
      DONE:       if (ack) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Both rise and fall detections carry the same synchroniser delay, so differences are exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      meas_cnt  <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      offset    <= '0;
      high_time <= '0;
      period    <= '0;
    end else begin
      busy  <= (state_next != IDLE);
      valid <= (state_next == DONE);

      if ((state_next != state) || !waiting)
        wait_cnt <= '0;
      else
        wait_cnt <= wait_cnt + WW'(1);

      if (state == WAIT_RISE && rise)
        meas_cnt <= '0;
      else
        meas_cnt <= meas_inc;

      if (state == WAIT_RISE && rise)
        offset <= phase_adj;
      if (state == WAIT_FALL && fall)
        high_time <= meas_inc;
      if (state == WAIT_RISE2 && rise)
        period <= meas_inc;

      if (to_timeout) begin
        timeout   <= 1'b1;
        offset    <= '0;
        high_time <= '0;
        period    <= '0;
      end else if (state == DONE && ack) begin
        timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_phase_meter.sv
// Table-driven bench for phase_meter: a square-wave generator locked to a reference model
// places rising edges at chosen positions; hand sequences cover timeout, handshake and reset.
module tb_phase_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  divide;
  logic        sig_in;
  logic        start;
  logic        ack;
  logic        busy, valid, timeout;
  logic [10:0] offset;
  logic [11:0] high_time, period;

  int checks   = 0;
  int failures = 0;

  int m_cnt  = 0;
  int m_half = 0;
  logic gen_en    = 1'b0;
  int   gen_phase = 0;

  typedef struct {
    int divide;
    int phase;
    int exp_offset;
    int exp_high;
    int exp_period;
  } vec_t;

  vec_t vecs[9];

  phase_meter #(
    .OFFSET_WIDTH(11),
    .CNT_WIDTH(12),
    .TIMEOUT_CYCLES(5000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .divide(divide),
    .sig_in(sig_in),
    .start(start),
    .ack(ack),
    .busy(busy),
    .valid(valid),
    .timeout(timeout),
    .offset(offset),
    .high_time(high_time),
    .period(period)
  );

  always #10 clk = ~clk;

  // Reference timebase model, from the divider rule
  always @(posedge clk) begin
    if (rst) begin
      m_cnt  <= 0;
      m_half <= 0;
    end else if (m_cnt >= int'(divide)) begin
      m_cnt  <= 0;
      m_half <= 1 - m_half;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  function automatic int modelPos();
    return m_half * (int'(divide) + 1) + m_cnt;
  endfunction

  // 50% duty wave whose first high sample lands at reference position gen_phase
  always @(negedge clk) begin
    int p, d;
    p = 2 * (int'(divide) + 1);
    d = ((modelPos() - gen_phase) % p + p) % p;
    sig_in = gen_en && (d < p / 2);
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic waitValid(input int bound, output int n);
    n = 0;
    while (!valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput("valid_reached", int'(valid), 1);
  endtask

  task automatic applyStimulus(input vec_t v);
    int n;
    gen_en = 1'b0;
    divide = 10'(v.divide);
    repeat (8) @(negedge clk);
    gen_phase = v.phase;
    gen_en    = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", int'(busy), 1);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitValid(4000, n);
  endtask

  task automatic ackResult();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checkOutput("valid_after_ack", int'(valid), 0);
    checkOutput("busy_after_ack", int'(busy), 0);
  endtask

  initial begin
    int n;
    vecs[0] = '{624, 100,  100,  625, 1250};
    vecs[1] = '{624, 700,  1099, 625, 1250};
    vecs[2] = '{624, 1,    1,    625, 1250};
    vecs[3] = '{624, 1249, 1648, 625, 1250};
    vecs[4] = '{624, 623,  623,  625, 1250};
    vecs[5] = '{624, 624,  624,  625, 1250};
    vecs[6] = '{99,  50,   50,   100, 200};
    vecs[7] = '{99,  199,  1123, 100, 200};
    vecs[8] = '{99,  150,  1074, 100, 200};

    rst    = 1'b1;
    divide = 10'd624;
    start  = 1'b0;
    ack    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_valid", int'(valid), 0);
    checkOutput("reset_timeout", int'(timeout), 0);
    checkOutput("reset_offset", int'(offset), 0);
    checkOutput("reset_high_time", int'(high_time), 0);
    checkOutput("reset_period", int'(period), 0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_offset", i), int'(offset), vecs[i].exp_offset);
      checkOutput($sformatf("vec%0d_high_time", i), int'(high_time), vecs[i].exp_high);
      checkOutput($sformatf("vec%0d_period", i), int'(period), vecs[i].exp_period);
      checkOutput($sformatf("vec%0d_timeout", i), int'(timeout), 0);
      ackResult();
    end

    // Stuck-low input: abort after the full wait in WAIT_RISE
    gen_en = 1'b0;
    divide = 10'd624;
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!valid && n < 6000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("to_cycles", n, 5002);
    checkOutput("to_valid", int'(valid), 1);
    checkOutput("to_timeout", int'(timeout), 1);
    checkOutput("to_offset", int'(offset), 0);
    checkOutput("to_high_time", int'(high_time), 0);
    checkOutput("to_period", int'(period), 0);
    ackResult();
    checkOutput("to_timeout_clear", int'(timeout), 0);

    // Hold result without ack while start is pulsed; then ack and start together
    applyStimulus(vecs[0]);
    for (int i = 0; i < 20; i++) begin
      start = (i % 2 == 0);
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("hold_valid", int'(valid), 1);
    checkOutput("hold_busy", int'(busy), 1);
    checkOutput("hold_offset", int'(offset), 100);
    checkOutput("hold_high_time", int'(high_time), 625);
    checkOutput("hold_period", int'(period), 1250);
    ack   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    ack   = 1'b0;
    start = 1'b0;
    checkOutput("ackstart_valid", int'(valid), 0);
    checkOutput("ackstart_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    checkOutput("ackstart_stays_idle", int'(busy), 0);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle_ack_busy", int'(busy), 0);
    checkOutput("idle_ack_valid", int'(valid), 0);

    // Reset while measuring the high phase
    gen_en = 1'b0;
    divide = 10'd624;
    repeat (8) @(negedge clk);
    gen_phase = 100;
    gen_en    = 1'b1;
    n = 0;
    while (modelPos() != 735 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (modelPos() != 160 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst_mid_busy_before", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_mid_busy", int'(busy), 0);
    checkOutput("rst_mid_valid", int'(valid), 0);
    checkOutput("rst_mid_offset", int'(offset), 0);
    checkOutput("rst_mid_high_time", int'(high_time), 0);
    repeat (5) @(negedge clk);
    checkOutput("rst_mid_no_result", int'(valid), 0);
    applyStimulus(vecs[0]);
    checkOutput("post_rst_offset", int'(offset), 100);
    checkOutput("post_rst_high_time", int'(high_time), 625);
    checkOutput("post_rst_period", int'(period), 1250);
    ackResult();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
